attention_av_stream_ctrl: RTL and testbench

Streaming front/back end for the AV-multiply engine. Collects A rows and V rows (with per-token precision codes) from two valid/ready streams and packs them into the engine's flattened A/V buses and precision array. It then pulses the engine's start, captures the flattened Z result on the engine's done pulse, and streams Z out row by row on a valid/ready stream. It is the initiator side of the engine's start/done interface.

---
 rtl/attention_av_stream_ctrl_if.sv | 70 +++++++
 rtl/attention_av_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_attention_av_stream_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attention_av_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : attention_av_stream_ctrl_if
// Purpose  : Bundles the A/V input streams, the AV-multiply engine start/done
//            bus and the Z output stream of attention_av_stream_ctrl.
// Ports    : none (signal container only)
//   a_valid/a_ready/a_data         A row stream (one token row per beat)
//   v_valid/v_ready/v_data/v_prec  V row stream plus per-token precision code
//   mul_start/mul_done             engine start pulse / completion pulse
//   mul_A/mul_V/token_precision    flattened operands held for the engine
//   mul_Z                          flattened engine result
//   z_valid/z_ready/z_data/z_last  Z row output stream
//   busy                           controller is outside its fill state
// Modports : master - the controller; slave - sources, sinks and engine
// Revision : 1.0 - initial release
// ============================================================================
interface attention_av_stream_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
);
  logic                           a_valid;
  logic                           a_ready;
  logic [DATA_WIDTH*N*L-1:0]      a_data;

  logic                           v_valid;
  logic                           v_ready;
  logic [DATA_WIDTH*N*E-1:0]      v_data;
  logic [3:0]                     v_prec;

  logic                           mul_start;
  logic                           mul_done;
  logic [DATA_WIDTH*L*N*L-1:0]    mul_A;
  logic [DATA_WIDTH*L*N*E-1:0]    mul_V;
  logic [L-1:0][3:0]              token_precision;
  logic [DATA_WIDTH*L*N*E-1:0]    mul_Z;

  logic                           z_valid;
  logic                           z_ready;
  logic [DATA_WIDTH*N*E-1:0]      z_data;
  logic                           z_last;

  logic                           busy;

  modport master (
    input  a_valid, a_data,
    output a_ready,
    input  v_valid, v_data, v_prec,
    output v_ready,
    output mul_start, mul_A, mul_V, token_precision,
    input  mul_done, mul_Z,
    output z_valid, z_data, z_last,
    input  z_ready,
    output busy
  );

  modport slave (
    output a_valid, a_data,
    input  a_ready,
    output v_valid, v_data, v_prec,
    input  v_ready,
    input  mul_start, mul_A, mul_V, token_precision,
    output mul_done, mul_Z,
    input  z_valid, z_data, z_last,
    output z_ready,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/attention_av_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : attention_av_stream_ctrl
// Purpose  : Streaming front/back end for the AV-multiply engine. Collects L
//            A rows and L V rows (with per-token precision codes), holds them
//            on the engine's flattened buses, pulses start, captures the
//            flattened Z result on done and streams it out row by row.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            av_if  - master modport of attention_av_stream_ctrl_if
//                     (A/V input streams, engine bus, Z output stream, busy)
// Revision : 1.0 - initial release
// ============================================================================
module attention_av_stream_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int E          = 8
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  attention_av_stream_ctrl_if.master   av_if
);

  localparam int CW       = $clog2(L + 1);
  localparam int c_row_a  = DATA_WIDTH * N * L;
  localparam int c_row_v  = DATA_WIDTH * N * E;

  localparam logic [CW-1:0] c_cnt_full = CW'(L);
  localparam logic [CW-1:0] c_cnt_last = CW'(L - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                        r_state;
  logic [CW-1:0]                 r_a_cnt;
  logic [CW-1:0]                 r_v_cnt;
  logic [CW-1:0]                 r_z_cnt;
  logic                          r_mul_start;
  logic                          r_z_valid;
  logic [DATA_WIDTH*L*N*L-1:0]   r_mul_A;
  logic [DATA_WIDTH*L*N*E-1:0]   r_mul_V;
  logic [L-1:0][3:0]             r_prec;
  logic [DATA_WIDTH*L*N*E-1:0]   r_zbuf;

  // --------------------------------------------------------------------------
  // Combinational next-state / handshake decode
  // --------------------------------------------------------------------------
  state_t                        w_state_nxt;
  logic [CW-1:0]                 w_a_cnt_nxt;
  logic [CW-1:0]                 w_v_cnt_nxt;
  logic [CW-1:0]                 w_z_cnt_nxt;
  logic                          w_a_ready;
  logic                          w_v_ready;
  logic                          w_a_hs;
  logic                          w_v_hs;
  logic                          w_z_hs;
  logic                          w_capture;
  logic [c_row_v-1:0]            w_z_data;

  always_comb begin
    w_state_nxt = r_state;
    w_a_cnt_nxt = r_a_cnt;
    w_v_cnt_nxt = r_v_cnt;
    w_z_cnt_nxt = r_z_cnt;
    w_a_ready   = 1'b0;
    w_v_ready   = 1'b0;
    w_a_hs      = 1'b0;
    w_v_hs      = 1'b0;
    w_z_hs      = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      S_FILL: begin
        w_a_ready = (r_a_cnt < c_cnt_full);
        w_v_ready = (r_v_cnt < c_cnt_full);
        w_a_hs    = av_if.a_valid && w_a_ready;
        w_v_hs    = av_if.v_valid && w_v_ready;
        if (w_a_hs) w_a_cnt_nxt = r_a_cnt + c_cnt_one;
        if (w_v_hs) w_v_cnt_nxt = r_v_cnt + c_cnt_one;
        // Decide on the post-edge counts so that start follows the final
        // fill beat by exactly one cycle.
        if ((w_a_cnt_nxt == c_cnt_full) && (w_v_cnt_nxt == c_cnt_full)) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (av_if.mul_done) begin
          w_capture   = 1'b1;
          w_z_cnt_nxt = '0;
          w_state_nxt = S_DRAIN;
        end
      end

      S_DRAIN: begin
        w_z_hs = r_z_valid && av_if.z_ready;
        if (w_z_hs) begin
          if (r_z_cnt == c_cnt_last) begin
            // Block complete: rearm both fill counters for the next block.
            w_a_cnt_nxt = '0;
            w_v_cnt_nxt = '0;
            w_z_cnt_nxt = '0;
            w_state_nxt = S_FILL;
          end else begin
            w_z_cnt_nxt = r_z_cnt + c_cnt_one;
          end
        end
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered control outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_a_cnt     <= '0;
      r_v_cnt     <= '0;
      r_z_cnt     <= '0;
      r_mul_start <= 1'b0;
      r_z_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a_cnt     <= w_a_cnt_nxt;
      r_v_cnt     <= w_v_cnt_nxt;
      r_z_cnt     <= w_z_cnt_nxt;
      // Both flags are decoded from the next state so they line up exactly
      // with the registered state they describe.
      r_mul_start <= (w_state_nxt == S_START);
      r_z_valid   <= (w_state_nxt == S_DRAIN);
    end
  end

  // --------------------------------------------------------------------------
  // Operand and result storage
  // Rows are written only on their own handshake, so the buses stay frozen
  // from the last fill beat until the next block starts filling.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_A <= '0;
      r_mul_V <= '0;
      r_prec  <= '0;
      r_zbuf  <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (w_a_hs && (r_a_cnt == CW'(k))) begin
          r_mul_A[k*c_row_a +: c_row_a] <= av_if.a_data;
        end
        if (w_v_hs && (r_v_cnt == CW'(k))) begin
          r_mul_V[k*c_row_v +: c_row_v] <= av_if.v_data;
          r_prec[k]                     <= av_if.v_prec;
        end
      end
      if (w_capture) begin
        r_zbuf <= av_if.mul_Z;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Z row select
  // --------------------------------------------------------------------------
  always_comb begin
    w_z_data = '0;
    for (int k = 0; k < L; k++) begin
      if (r_z_cnt == CW'(k)) begin
        w_z_data = r_zbuf[k*c_row_v +: c_row_v];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign av_if.a_ready         = w_a_ready;
  assign av_if.v_ready         = w_v_ready;
  assign av_if.mul_start       = r_mul_start;
  assign av_if.mul_A           = r_mul_A;
  assign av_if.mul_V           = r_mul_V;
  assign av_if.token_precision = r_prec;
  assign av_if.z_valid         = r_z_valid;
  assign av_if.z_data          = w_z_data;
  assign av_if.z_last          = r_z_valid && (r_z_cnt == c_cnt_last);
  assign av_if.busy            = (r_state != S_FILL);

endmodule
`default_nettype wire

// File: tb/tb_attention_av_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_attention_av_stream_ctrl
// Purpose  : Self-checking bench for attention_av_stream_ctrl. Blocks of A/V
//            rows are generated into element arrays, streamed with random
//            gaps, and the engine buses and Z stream are compared against
//            those arrays.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_attention_av_stream_ctrl;

  localparam int DW = 16;
  localparam int L  = 8;
  localparam int N  = 1;
  localparam int E  = 8;
  localparam int RA = DW * N * L;
  localparam int RV = DW * N * E;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  attention_av_stream_ctrl_if #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) bus ();

  attention_av_stream_ctrl #(.DATA_WIDTH(DW), .L(L), .N(N), .E(E)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .av_if (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference block contents, element-wise
  logic [DW-1:0] mA [L][N*L];
  logic [DW-1:0] mV [L][N*E];
  logic [DW-1:0] mZ [L][N*E];
  logic [3:0]    mP [L];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RA-1:0] row_a(input int r);
    logic [RA-1:0] v;
    for (int j = 0; j < N*L; j++) v[j*DW +: DW] = mA[r][j];
    return v;
  endfunction

  function automatic logic [RV-1:0] row_v(input int r);
    logic [RV-1:0] v;
    for (int j = 0; j < N*E; j++) v[j*DW +: DW] = mV[r][j];
    return v;
  endfunction

  function automatic logic [RV-1:0] row_z(input int r);
    logic [RV-1:0] v;
    for (int j = 0; j < N*E; j++) v[j*DW +: DW] = mZ[r][j];
    return v;
  endfunction

  function automatic logic [4*L-1:0] prec_vec();
    logic [4*L-1:0] v;
    for (int k = 0; k < L; k++) v[k*4 +: 4] = mP[k];
    return v;
  endfunction

  // dmode 0: fixed arithmetic patterns; otherwise random data.
  // pmode 0: all FP16 (2); 1: cycling 0..3; 2: random codes.
  task automatic gen_block(input int dmode, input int pmode);
    for (int k = 0; k < L; k++) begin
      for (int j = 0; j < N*L; j++)
        mA[k][j] = (dmode == 0) ? DW'(k + (j % L)) : DW'($urandom);
      for (int j = 0; j < N*E; j++) begin
        mV[k][j] = (dmode == 0) ? DW'(k*E + (j % E)) : DW'($urandom);
        mZ[k][j] = (dmode == 0) ? DW'(16'h0100 + k) : DW'($urandom);
      end
      case (pmode)
        0:       mP[k] = 4'd2;
        1:       mP[k] = 4'(k % 4);
        default: mP[k] = 4'($urandom_range(15));
      endcase
    end
  endtask

  task automatic drive_z(input bit junk);
    for (int k = 0; k < L; k++)
      for (int j = 0; j < N*E; j++)
        bus.mul_Z[(k*N*E + j)*DW +: DW] = junk ? DW'($urandom) : mZ[k][j];
  endtask

  task automatic check_arrays(input string where);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s mul_A row%0d", where, k), bus.mul_A[k*RA +: RA], row_a(k));
      chk($sformatf("%s mul_V row%0d", where, k), bus.mul_V[k*RV +: RV], row_v(k));
    end
    chk($sformatf("%s token_precision", where), bus.token_precision, prec_vec());
  endtask

  task automatic check_zero(input string where);
    chk($sformatf("%s mul_start", where), bus.mul_start, 0);
    chk($sformatf("%s z_valid", where), bus.z_valid, 0);
    chk($sformatf("%s z_last", where), bus.z_last, 0);
    chk($sformatf("%s busy", where), bus.busy, 0);
    chk($sformatf("%s z_data", where), bus.z_data, 0);
    chk($sformatf("%s token_precision", where), bus.token_precision, 0);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s mul_A row%0d", where, k), bus.mul_A[k*RA +: RA], 0);
      chk($sformatf("%s mul_V row%0d", where, k), bus.mul_V[k*RV +: RV], 0);
    end
  endtask

  // Called and returns at a falling edge. Streams one block of A and V rows;
  // returns in the cycle after the final accepted beat.
  task automatic do_fill(input int gap, input bit v_first, input bit extra, input bit spurious);
    int ai = 0;
    int vi = 0;
    int cyc = 0;
    while ((ai < L || vi < L) && cyc < 400) begin
      chk("fill a_ready", bus.a_ready, (ai < L));
      chk("fill v_ready", bus.v_ready, (vi < L));
      chk("fill busy", bus.busy, 0);
      chk("fill mul_start", bus.mul_start, 0);
      chk("fill z_valid", bus.z_valid, 0);
      if (ai < L) begin
        bus.a_valid = (!v_first || vi >= 4) && ($urandom_range(99) >= gap);
        bus.a_data  = row_a(ai);
      end else begin
        // An extra beat offered to a full stream must be left waiting.
        bus.a_valid = extra;
        bus.a_data  = RA'({$urandom, $urandom, $urandom, $urandom});
      end
      bus.v_valid = (vi < L) && ($urandom_range(99) >= gap);
      bus.v_data  = row_v(vi < L ? vi : 0);
      bus.v_prec  = mP[vi < L ? vi : 0];
      bus.mul_done = spurious && (cyc == 2);
      drive_z(1'b1);
      if (bus.a_valid && ai < L) ai++;
      if (bus.v_valid && vi < L) vi++;
      cyc++;
      @(negedge clk);
    end
    bus.a_valid  = 1'b0;
    bus.v_valid  = 1'b0;
    bus.mul_done = 1'b0;
    chk("fill a count", ai, L);
    chk("fill v count", vi, L);
    chk("start pulse", bus.mul_start, 1);
    chk("start busy", bus.busy, 1);
    chk("start a_ready", bus.a_ready, 0);
    chk("start v_ready", bus.v_ready, 0);
  endtask

  // Engine stand-in: waits 'delay' cycles after start, then pulses done with
  // the reference Z; returns in the cycle after the done edge.
  task automatic run_engine(input int delay);
    for (int c = 0; c < delay; c++) begin
      @(negedge clk);
      chk("wait mul_start", bus.mul_start, 0);
      chk("wait busy", bus.busy, 1);
      chk("wait z_valid", bus.z_valid, 0);
      chk("wait a_ready", bus.a_ready, 0);
      if (c == 0) check_arrays("wait");
    end
    bus.mul_done = 1'b1;
    drive_z(1'b0);
    @(negedge clk);
    bus.mul_done = 1'b0;
    drive_z(1'b1);
  endtask

  // zmode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: random.
  task automatic do_drain(input int zmode, input int stop_after, input bit spurious);
    int zi = 0;
    int cyc = 0;
    bit arr_done = 0;
    while (zi < stop_after && cyc < 200) begin
      chk("drain z_valid", bus.z_valid, 1);
      chk($sformatf("drain z_data row%0d", zi), bus.z_data, row_z(zi));
      chk("drain z_last", bus.z_last, (zi == L-1));
      chk("drain busy", bus.busy, 1);
      chk("drain a_ready", bus.a_ready, 0);
      chk("drain v_ready", bus.v_ready, 0);
      chk("drain mul_start", bus.mul_start, 0);
      if (zi == L-1 && !arr_done) begin
        check_arrays("drain");
        arr_done = 1;
      end
      case (zmode)
        0:       bus.z_ready = 1'b1;
        1:       bus.z_ready = (cyc % 3 == 0);
        default: bus.z_ready = 1'($urandom_range(1));
      endcase
      bus.mul_done = spurious && (cyc % 4 == 1);
      drive_z(1'b1);
      if (bus.z_ready) zi++;
      cyc++;
      @(negedge clk);
    end
    bus.z_ready  = 1'b0;
    bus.mul_done = 1'b0;
    chk("drain beat count", zi, stop_after);
    if (stop_after == L) begin
      chk("post z_valid", bus.z_valid, 0);
      chk("post z_last", bus.z_last, 0);
      chk("post busy", bus.busy, 0);
      chk("post a_ready", bus.a_ready, 1);
      chk("post v_ready", bus.v_ready, 1);
    end
  endtask

  // Reset pulse in the middle of a cycle; outputs must clear without a clock.
  task automatic do_reset_mid(input string where);
    #2 rst_n = 1'b0;
    #1 check_zero(where);
    @(negedge clk);
    rst_n = 1'b1;
    chk({where, " a_ready"}, bus.a_ready, 1);
    chk({where, " v_ready"}, bus.v_ready, 1);
  endtask

  initial begin
    bus.a_valid  = 1'b0;
    bus.a_data   = '0;
    bus.v_valid  = 1'b0;
    bus.v_data   = '0;
    bus.v_prec   = '0;
    bus.mul_done = 1'b0;
    bus.mul_Z    = '0;
    bus.z_ready  = 1'b0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    chk("reset a_ready", bus.a_ready, 1);
    chk("reset v_ready", bus.v_ready, 1);

    // Block 1: fixed patterns, back-to-back beats, Z rows 0x0100+l
    gen_block(0, 0);
    do_fill(0, 1'b0, 1'b0, 1'b0);
    check_arrays("start");
    run_engine(3);
    do_drain(0, L, 1'b0);

    // Block 2: V first, random gaps, extra A beat, spurious done, backpressure
    gen_block(1, 1);
    do_fill(40, 1'b1, 1'b1, 1'b1);
    run_engine(5);
    do_drain(1, L, 1'b1);

    // Block 3: reset while waiting for the engine
    gen_block(1, 2);
    do_fill(30, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    do_reset_mid("reset in wait");

    // Block 4: reset part-way through the drain
    gen_block(1, 2);
    do_fill(20, 1'b0, 1'b1, 1'b0);
    run_engine(2);
    do_drain(2, 3, 1'b0);
    do_reset_mid("reset in drain");

    // Block 5: fresh full block after the resets
    gen_block(1, 2);
    do_fill(50, 1'b1, 1'b0, 1'b1);
    run_engine(4);
    do_drain(2, L, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
